// File: rtl/updown_sweep_ctrl.sv
// Triangle-sweep controller for a W-bit up/down counter: load lo, count to hi, back to lo, repeat.
// Optional macro SWEEP_PAUSE_EN adds a pause input that freezes stepping in UP/DOWN.
module updown_sweep_ctrl #(
  parameter int W   = 4,
  parameter int SW  = 8,
  parameter int DIV = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_lo,
  input  logic [W-1:0]  cmd_hi,
  input  logic [SW-1:0] cmd_sweeps,
  input  logic          abort,
`ifdef SWEEP_PAUSE_EN
  input  logic          pause,
`endif
  input  logic [W-1:0]  count_in,
  output logic          cnt_enable,
  output logic          cnt_load,
  output logic          cnt_up_down,
  output logic [W-1:0]  cnt_data_in,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [SW-1:0] sweeps_done
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, UP, DOWN, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic [SW-1:0] sweeps_q, sweeps_d, sd_q, sd_d, sd_inc;
  logic [PW-1:0] presc_q, presc_d;
  logic          err_q, err_d;
  logic          tick, pause_w;

`ifdef SWEEP_PAUSE_EN
  assign pause_w = pause;
`else
  assign pause_w = 1'b0;
`endif

  assign tick        = (presc_q == PW'(DIV - 1));
  assign sd_inc      = sd_q + SW'(1);
  assign err         = err_q;
  assign sweeps_done = sd_q;

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    hi_d        = hi_q;
    sweeps_d    = sweeps_q;
    sd_d        = sd_q;
    presc_d     = presc_q;
    err_d       = 1'b0;
    cnt_enable  = 1'b0;
    cnt_load    = 1'b0;
    cnt_up_down = 1'b0;
    cnt_data_in = '0;
    done        = 1'b0;
    cmd_ready   = (state_q == IDLE);
    busy        = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (cmd_valid && !abort) begin
          lo_d     = cmd_lo;
          hi_d     = cmd_hi;
          sweeps_d = cmd_sweeps;
          sd_d     = '0;
          if (cmd_lo > cmd_hi) err_d = 1'b1;
          else                 state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_enable  = 1'b1;
        cnt_load    = 1'b1;
        cnt_data_in = lo_q;
        presc_d     = '0;
        state_d     = UP;
      end
      UP: begin
        if (!pause_w) begin
          if (tick) begin
            presc_d = '0;
            if (count_in == hi_q) begin
              state_d = DOWN;
            end else begin
              cnt_enable  = 1'b1;
              cnt_up_down = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      DOWN: begin
        if (!pause_w) begin
          if (tick) begin
            presc_d = '0;
            if (count_in == lo_q) begin
              // Saturation only matters for endless (sweeps == 0) runs.
              sd_d = (sd_q == '1) ? sd_q : sd_inc;
              if (sweeps_q != '0 && sd_inc == sweeps_q) state_d = DONE;
              else                                       state_d = UP;
            end else begin
              cnt_enable = 1'b1;
            end
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything decided above, including an offered command.
    if (abort) begin
      state_d     = IDLE;
      lo_d        = lo_q;
      hi_d        = hi_q;
      sweeps_d    = sweeps_q;
      sd_d        = sd_q;
      presc_d     = '0;
      err_d       = 1'b0;
      cnt_enable  = 1'b0;
      cnt_load    = 1'b0;
      cnt_up_down = 1'b0;
      cnt_data_in = '0;
      done        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      sweeps_q <= '0;
      sd_q     <= '0;
      presc_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      sweeps_q <= sweeps_d;
      sd_q     <= sd_d;
      presc_q  <= presc_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
Controller that drives the team's 4-bit up/down counter (enable/load/up_down/data_in control inputs, count output) through programmed triangle sweeps. A command (lo, hi, sweep count) is accepted over a valid/ready handshake. The controller then loads lo, counts up to hi, counts back down to lo, and repeats for the requested number of sweeps. It sits between a register/CPU front end and the counter instance, and observes the counter's count output to make its decisions.

Parameters:
W, 4, counter width; width of lo, hi, cnt_data_in, count_in
SW, 8, width of sweep-count fields
DIV, 1, step prescaler: one counter step per DIV clocks in UP/DOWN (DIV >= 1)

Ports:
clk  in  1  single clock; all logic on posedge
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_lo  in  W  lower sweep bound
cmd_hi  in  W  upper sweep bound
cmd_sweeps  in  SW  sweeps to run; 0 = run until abort
abort  in  1  synchronous stop, any state
count_in  in  W  counter's current count
cnt_enable  out  1  to counter enable
cnt_load  out  1  to counter load
cnt_up_down  out  1  to counter up_down (1 = up)
cnt_data_in  out  W  to counter data_in
busy  out  1  high in LOAD/UP/DOWN/DONE
done  out  1  one-cycle pulse at normal completion
err  out  1  one-cycle pulse on rejected command
sweeps_done  out  SW  completed sweeps of current or last command

Behaviour:
- Reset (rst low, async): state=IDLE, cmd_ready=1, busy=0, done=0, err=0, cnt_enable=0, cnt_load=0, cnt_up_down=0, cnt_data_in=0, sweeps_done=0, prescaler=0.
- Handshake: a command is accepted on a clk edge with cmd_valid && cmd_ready. At acceptance, lo, hi and sweeps are captured and sweeps_done is cleared.
- Rejected command: if cmd_lo > cmd_hi at acceptance, err pulses the next cycle and the state stays IDLE.
- States: IDLE, LOAD, UP, DOWN, DONE.
- IDLE to LOAD: on a valid accepted command.
- LOAD: lasts exactly 1 cycle. Drives cnt_enable=1, cnt_load=1, cnt_data_in=lo. Then goes to UP.
- Prescaler: clears on entry to UP or DOWN. tick = (prescaler == DIV-1). Wraps to 0 on tick. With DIV=1, tick occurs every cycle.
- UP, on tick:
  - if count_in == hi, go to DOWN; no step is issued that cycle.
  - otherwise, cnt_enable=1 and cnt_up_down=1 for that cycle.
- DOWN, on tick:
  - if count_in == lo, sweeps_done increments and the sweep is complete.
  - after a complete sweep: if sweeps != 0 and sweeps_done+1 == sweeps, go to DONE; else go to UP.
  - otherwise, cnt_enable=1 and cnt_up_down=0 for that cycle.
- Between ticks: cnt_enable=0.
- Outside LOAD/UP/DOWN: cnt_enable=0 and cnt_load=0.
- DONE: lasts 1 cycle, done=1, then IDLE.
- sweeps_done: saturates at all-ones when sweeps == 0. It holds its value in IDLE until the next accepted command.
- lo == hi: each sweep takes one UP tick and one DOWN tick with no steps issued.
- abort: has priority over all transitions. The next state is IDLE and no counter control is asserted in the abort cycle. done does not pulse and sweeps_done holds. Asserting abort in IDLE has no effect, and the command offered in the same cycle is not accepted.
- The counter's count follows the controls with 1-cycle latency. All decisions use count_in as sampled in the current cycle.

Optional Feature:
SWEEP_PAUSE_EN
- With the macro defined: adds input port pause (1 bit). While pause=1 in UP/DOWN, the prescaler freezes, cnt_enable=0, and the state holds. LOAD and DONE are unaffected. abort still wins over pause.
- Without the macro: no pause port, and behaviour is exactly as above.

Test Plan:
- W=4, DIV=1, lo=3, hi=5, sweeps=1 -> LOAD 1 cycle with data_in=3. count trace 3,4,5,5,4,3,3. done pulses once. sweeps_done=1. cmd_ready returns to 1.
- lo=9, hi=2 -> err pulse 1 cycle. No cnt_enable ever asserted. State stays IDLE.
- lo=0, hi=15, sweeps=2, DIV=3 -> steps every 3rd clock. Count never exceeds 15 or wraps below 0. done after 2 sweeps. sweeps_done=2.
- sweeps=0, lo=1, hi=2 -> runs continuously with sweeps_done incrementing. abort mid-UP: IDLE next cycle, no done, cnt_enable=0.
- lo=hi=7, sweeps=3 -> count stays 7 after load. done after 3 sweeps with zero counter steps.
- async rst dropped mid-DOWN -> all outputs at reset values immediately. A new command is accepted after rst returns high.
